even_odd_demux: RTL

Parity demultiplexer: accepts a single write stream and steers each word by its LSB into one of two independent FIFOs, each drained by its own consumer through a registered read port. It is the split-side counterpart of the parity merger, used where even and odd words must be drained at different rates. Words that cannot be stored are dropped and counted.

---
 rtl/even_odd_demux.sv | 128 ++++++++++++
 1 files changed

// File: rtl/even_odd_demux.sv
// rtl/even_odd_demux.sv - parity demux: one write stream steered by din[0] into two independently drained FIFOs
// Optional parity-order checker built when EVEN_ODD_DEMUX_ORDER_CHK_EN is defined.
module even_odd_demux #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 40,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen,
   input  logic [DATA_W-1:0] din,
   input  logic              even_ren,
   output logic [DATA_W-1:0] even_dout,
   output logic              even_dvalid,
   output logic              even_empty,
   output logic [CNT_W-1:0]  even_count,
   input  logic              odd_ren,
   output logic [DATA_W-1:0] odd_dout,
   output logic              odd_dvalid,
   output logic              odd_empty,
   output logic [CNT_W-1:0]  odd_count,
   output logic [15:0]       drop_cnt,
   output logic              seq_err
);

   localparam int PTR_W = $clog2(DEPTH);

   // Index 0 is the even side, index 1 the odd side.
   logic [DATA_W-1:0] mem    [2][DEPTH];
   logic [PTR_W-1:0]  wr_ptr [2];
   logic [PTR_W-1:0]  rd_ptr [2];
   logic [CNT_W-1:0]  count  [2];
   logic [DATA_W-1:0] dout_q [2];
   logic [1:0]        dvalid_q;
   logic [1:0]        ren;
   logic [1:0]        wr_req;
   logic [1:0]        rd_ok;
   logic [1:0]        wr_ok;
   logic              drop;
   logic              accept;
   logic [15:0]       drop_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A full FIFO still takes a write when it is popped in the same cycle.
   always_comb begin
      ren    = {odd_ren, even_ren};
      wr_req = '0;
      rd_ok  = '0;
      wr_ok  = '0;
      for (int s = 0; s < 2; s++) begin
         wr_req[s] = wen && (din[0] == s[0]);
         rd_ok[s]  = ren[s] && (count[s] != '0);
         wr_ok[s]  = wr_req[s] && ((count[s] != CNT_W'(DEPTH)) || ren[s]);
      end
      accept = |wr_ok;
      drop   = wen && !accept;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < 2; s++) begin
            if (wr_ok[s]) mem[s][wr_ptr[s]] <= din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            wr_ptr[s] <= '0;
            rd_ptr[s] <= '0;
            count[s]  <= '0;
            dout_q[s] <= '0;
         end
         dvalid_q <= '0;
         drop_q   <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (wr_ok[s]) wr_ptr[s] <= ptr_inc(wr_ptr[s]);
            if (rd_ok[s]) begin
               rd_ptr[s] <= ptr_inc(rd_ptr[s]);
               dout_q[s] <= mem[s][rd_ptr[s]];
            end
            dvalid_q[s] <= rd_ok[s];
            case ({wr_ok[s], rd_ok[s]})
               2'b10:   count[s] <= count[s] + 1'b1;
               2'b01:   count[s] <= count[s] - 1'b1;
               default: count[s] <= count[s];
            endcase
         end
         if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 1'b1;
      end
   end

   assign even_dout   = dout_q[0];
   assign even_dvalid = dvalid_q[0];
   assign even_count  = count[0];
   assign even_empty  = (count[0] == '0);
   assign odd_dout    = dout_q[1];
   assign odd_dvalid  = dvalid_q[1];
   assign odd_count   = count[1];
   assign odd_empty   = (count[1] == '0);
   assign drop_cnt    = drop_q;

`ifdef EVEN_ODD_DEMUX_ORDER_CHK_EN
   // Tracker starts at "odd" so the first accepted word is expected even.
   logic last_par;
   logic seq_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_par  <= 1'b1;
         seq_err_q <= 1'b0;
      end else if (accept) begin
         if (din[0] == last_par) seq_err_q <= 1'b1;
         last_par <= din[0];
      end
   end

   assign seq_err = seq_err_q;
`else
   assign seq_err = 1'b0;
`endif

endmodule
